// File: rtl/synth_player_pkg.sv
// Shared opcodes, command field positions and FSM states for the synth register-write player.
package synth_player_pkg;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_WAIT  = 2'b01;
    localparam logic [1:0] OP_JUMP  = 2'b10;
    localparam logic [1:0] OP_HALT  = 2'b11;

    localparam int CMD_W    = 16;
    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 14;
    localparam int ADDR_MSB = 11;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;
    localparam int WAIT_MSB = 13;
    localparam int WAIT_LSB = 0;
    localparam int WAIT_W   = WAIT_MSB - WAIT_LSB + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_STROBE,
        ST_GAP,
        ST_WAIT,
        ST_HALT
    } player_state_t;

endpackage

// File: rtl/synth_reg_player.sv
// Command sequencer: fetches 16-bit commands from a synchronous ROM and plays them out as
// one-cycle register writes, with timed waits, jumps and halt.
module synth_reg_player
    import synth_player_pkg::*;
#(
    parameter int ROM_AW     = 8,
    parameter int STROBE_GAP = 11,
    parameter int TICK_DIV   = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic              restart_i,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [CMD_W-1:0]  rom_data_i,
    output logic [7:0]        data_o,
    output logic [3:0]        addr_o,
    output logic              strobe_o,
    output logic              busy_o,
    output logic              halted_o
);

    // Wait counter must hold the largest N*TICK_DIV product, and never be narrower than 24 bits.
    localparam int CNT_RAW = WAIT_W + $clog2(TICK_DIV + 1);
    localparam int CNT_W   = (CNT_RAW > 24) ? CNT_RAW : 24;
    localparam int GAP_W   = (STROBE_GAP > 1) ? $clog2(STROBE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((STROBE_GAP > 1) ? STROBE_GAP - 2 : 0);

    player_state_t     state, state_next, resume_state;
    logic [ROM_AW-1:0] pc, pc_next;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_next, wait_len, wait_len_next, decoded_wait_len;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_next;
    logic [1:0]        opcode;
    logic              load_write;

    assign opcode           = rom_data_i[OP_MSB:OP_LSB];
    assign decoded_wait_len = CNT_W'(rom_data_i[WAIT_MSB:WAIT_LSB]) * CNT_W'(TICK_DIV);
    assign resume_state     = enable_i ? ST_FETCH : ST_IDLE;
    assign rom_addr_o       = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Instruction boundaries (end of GAP/WAIT, JUMP, WAIT 0) are where enable_i is honoured.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        wait_cnt_next = wait_cnt;
        wait_len_next = wait_len;
        gap_cnt_next  = gap_cnt;
        load_write    = 1'b0;
        if (restart_i) begin
            state_next    = ST_IDLE;
            pc_next       = '0;
            wait_cnt_next = '0;
            wait_len_next = '0;
            gap_cnt_next  = '0;
        end else begin
            unique case (state)
                ST_IDLE:  if (enable_i) state_next = ST_FETCH;
                ST_FETCH: state_next = ST_DECODE;
                ST_DECODE: begin
                    case (opcode)
                        OP_WRITE: begin
                            load_write = 1'b1;
                            pc_next    = pc + ROM_AW'(1);
                            state_next = ST_STROBE;
                        end
                        OP_WAIT: begin
                            pc_next       = pc + ROM_AW'(1);
                            wait_cnt_next = '0;
                            wait_len_next = decoded_wait_len;
                            state_next    = (decoded_wait_len == '0) ? resume_state : ST_WAIT;
                        end
                        OP_JUMP: begin
                            pc_next    = rom_data_i[ROM_AW-1:0];
                            state_next = resume_state;
                        end
                        default: state_next = ST_HALT;
                    endcase
                end
                ST_STROBE: begin
                    gap_cnt_next = '0;
                    state_next   = (STROBE_GAP > 1) ? ST_GAP : resume_state;
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) state_next = resume_state;
                    else gap_cnt_next = gap_cnt + GAP_W'(1);
                end
                ST_WAIT: begin
                    if (wait_cnt == wait_len - CNT_W'(1)) state_next = resume_state;
                    else wait_cnt_next = wait_cnt + CNT_W'(1);
                end
                ST_HALT: state_next = ST_HALT;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Status and strobe are registered from the next state so they line up with the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= '0;
            wait_cnt <= '0;
            wait_len <= '0;
            gap_cnt  <= '0;
            data_o   <= '0;
            addr_o   <= '0;
            strobe_o <= 1'b0;
            busy_o   <= 1'b0;
            halted_o <= 1'b0;
        end else begin
            pc       <= pc_next;
            wait_cnt <= wait_cnt_next;
            wait_len <= wait_len_next;
            gap_cnt  <= gap_cnt_next;
            if (load_write) begin
                data_o <= rom_data_i[DATA_MSB:DATA_LSB];
                addr_o <= rom_data_i[ADDR_MSB:ADDR_LSB];
            end
            strobe_o <= (state_next == ST_STROBE);
            busy_o   <= (state_next != ST_IDLE) && (state_next != ST_HALT);
            halted_o <= (state_next == ST_HALT);
        end
    end

endmodule

// File: tb/tb_synth_reg_player.sv
// Self-checking bench for synth_reg_player: a model ROM plus an instruction-level timing model.
module tb_synth_reg_player;

    localparam int ROM_AW     = 8;
    localparam int STROBE_GAP = 11;
    localparam int TICK_DIV   = 4;
    localparam int NEVER      = 32'h3fff_ffff;
    localparam int K_RUNNING  = 0;
    localparam int K_PAUSED   = 1;
    localparam int K_HALTED   = 2;

    typedef struct packed {
        int         cyc;
        logic [3:0] addr;
        logic [7:0] data;
    } strobe_ev_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable_i = 1'b0;
    logic              restart_i = 1'b0;
    logic [ROM_AW-1:0] rom_addr_o;
    logic [15:0]       rom_data = '0;
    logic [7:0]        data_o;
    logic [3:0]        addr_o;
    logic              strobe_o;
    logic              busy_o;
    logic              halted_o;

    logic [15:0] rom [256];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    strobe_ev_t  obs_q[$];
    strobe_ev_t  exp_q[$];

    synth_reg_player #(
        .ROM_AW    (ROM_AW),
        .STROBE_GAP(STROBE_GAP),
        .TICK_DIV  (TICK_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable_i  (enable_i),
        .restart_i (restart_i),
        .rom_addr_o(rom_addr_o),
        .rom_data_i(rom_data),
        .data_o    (data_o),
        .addr_o    (addr_o),
        .strobe_o  (strobe_o),
        .busy_o    (busy_o),
        .halted_o  (halted_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data <= rom[rom_addr_o];
        cyc      <= cyc + 1;
    end

    // Strobe monitor samples just after the edge that produced each cycle.
    always @(posedge clk) begin
        #1;
        if (strobe_o === 1'b1) obs_q.push_back('{cyc: cyc, addr: addr_o, data: data_o});
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [15:0] cmd_write(input logic [3:0] a, input logic [7:0] d);
        return {2'b00, 2'b00, a, d};
    endfunction
    function automatic logic [15:0] cmd_wait(input int n);
        return {2'b01, 14'(n)};
    endfunction
    function automatic logic [15:0] cmd_jump(input int target);
        return {2'b10, 6'b0, 8'(target)};
    endfunction

    // Instruction-level model: each command costs FETCH+DECODE plus its own cycles.
    task automatic model_exec(input int start_pc, input int fetch_t, input int disable_t,
                              input int horizon, output int end_pc, output int end_kind);
        int         pc = start_pc;
        int         t = fetch_t;
        bit         first = 1'b1;
        logic [15:0] cmd;
        end_kind = K_RUNNING;
        forever begin
            if (t > horizon) break;
            if (!first && (t - 1 >= disable_t)) begin
                end_kind = K_PAUSED;
                break;
            end
            first = 1'b0;
            cmd = rom[pc];
            if (cmd[15:14] == 2'b00) begin
                if (t + 2 <= horizon) exp_q.push_back('{cyc: t + 2, addr: cmd[11:8], data: cmd[7:0]});
                pc = (pc + 1) % 256;
                t  = t + STROBE_GAP + 2;
            end else if (cmd[15:14] == 2'b01) begin
                pc = (pc + 1) % 256;
                t  = t + 2 + int'(cmd[13:0]) * TICK_DIV;
            end else if (cmd[15:14] == 2'b10) begin
                pc = int'(cmd[7:0]);
                t  = t + 2;
            end else begin
                if (t + 2 <= horizon) end_kind = K_HALTED;
                break;
            end
        end
        end_pc = pc;
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom[i] = 16'hC000;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic restart_to_idle();
        @(negedge clk);
        enable_i  = 1'b0;
        restart_i = 1'b1;
        @(negedge clk);
        restart_i = 1'b0;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic enable_run(output int fetch_t);
        @(negedge clk);
        enable_i = 1'b1;
        fetch_t  = cyc + 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({data_o, addr_o, strobe_o, busy_o, halted_o, rom_addr_o} !== '0) begin
            errors++;
            $display("[TB] FAIL reset outputs: got data=%h addr=%h strobe=%b busy=%b halted=%b rom_addr=%h, expected all 0",
                     data_o, addr_o, strobe_o, busy_o, halted_o, rom_addr_o);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({busy_o, strobe_o, halted_o, rom_addr_o} !== '0) begin
                errors++;
                $display("[TB] FAIL idle disabled cycle %0d: got busy=%b strobe=%b halted=%b rom_addr=%h, expected all 0",
                         i, busy_o, strobe_o, halted_o, rom_addr_o);
            end
        end
    endtask

    task automatic test_basic_writes();
        int f, h, pc_end, kind;
        rom_clear();
        rom[0] = cmd_write(4'h1, 8'hA5);
        rom[1] = cmd_write(4'h0, 8'h5A);
        restart_to_idle();
        enable_run(f);
        h = f + 60;
        model_exec(0, f, NEVER, h, pc_end, kind);
        wait_until(h);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL basic strobe count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL basic strobe[%0d]: got cyc=%0d a=%h d=%h expected cyc=%0d a=%h d=%h",
                         i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
            end
        end
        checks++;
        if ({halted_o, busy_o, rom_addr_o, data_o, addr_o} !== {kind == K_HALTED, kind == K_RUNNING, 8'(pc_end), exp_q[$].data, exp_q[$].addr}) begin
            errors++;
            $display("[TB] FAIL basic final: got halted=%b busy=%b pc=%h data=%h addr=%h expected halted=%b busy=%b pc=%h data=%h addr=%h",
                     halted_o, busy_o, rom_addr_o, data_o, addr_o, kind == K_HALTED, kind == K_RUNNING, 8'(pc_end), exp_q[$].data, exp_q[$].addr);
        end
    endtask

    task automatic test_wait();
        int f, h, pc_end, kind;
        rom_clear();
        rom[0] = cmd_wait(3);
        rom[1] = cmd_write(4'h2, 8'h11);
        rom[2] = cmd_wait(0);
        rom[3] = cmd_write(4'h5, 8'hC3);
        restart_to_idle();
        enable_run(f);
        h = f + 70;
        model_exec(0, f, NEVER, h, pc_end, kind);
        wait_until(h);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL wait strobe count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL wait strobe[%0d]: got cyc=%0d a=%h d=%h expected cyc=%0d a=%h d=%h",
                         i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
            end
        end
        checks++;
        if (halted_o !== (kind == K_HALTED)) begin
            errors++;
            $display("[TB] FAIL wait halted: got %b expected %b", halted_o, kind == K_HALTED);
        end
    endtask

    task automatic test_jump_loop();
        int f, h, pc_end, kind;
        rom_clear();
        rom[0] = cmd_write(4'h3, 8'h01);
        rom[1] = cmd_jump(0);
        restart_to_idle();
        enable_run(f);
        h = f + 100;
        model_exec(0, f, NEVER, h, pc_end, kind);
        wait_until(h);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL loop strobe count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL loop strobe[%0d]: got cyc=%0d a=%h d=%h expected cyc=%0d a=%h d=%h",
                         i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
            end
        end
        checks++;
        if ({busy_o, halted_o} !== {kind == K_RUNNING, kind == K_HALTED}) begin
            errors++;
            $display("[TB] FAIL loop status: got busy=%b halted=%b expected busy=%b halted=%b",
                     busy_o, halted_o, kind == K_RUNNING, kind == K_HALTED);
        end
    endtask

    task automatic test_wrap();
        int f, h, pc_end, kind;
        for (int i = 0; i < 256; i++) rom[i] = cmd_write(4'($urandom), 8'($urandom));
        restart_to_idle();
        enable_run(f);
        h = f + 262 * (STROBE_GAP + 2);
        model_exec(0, f, NEVER, h, pc_end, kind);
        wait_until(h);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL wrap strobe count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL wrap strobe[%0d]: got cyc=%0d a=%h d=%h expected cyc=%0d a=%h d=%h",
                         i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_pause();
        int f, f2, d, h, pc_mid, pc_end, kind;
        rom_clear();
        for (int i = 0; i < 6; i++) rom[i] = cmd_write(4'($urandom), 8'($urandom));
        restart_to_idle();
        enable_run(f);
        d = f + 16 + $urandom_range(0, 9);
        model_exec(0, f, d, d + 20, pc_mid, kind);
        wait_until(d);
        enable_i = 1'b0;
        wait_until(d + 20);
        checks++;
        if ({busy_o, halted_o, rom_addr_o} !== {kind == K_RUNNING, kind == K_HALTED, 8'(pc_mid)}) begin
            errors++;
            $display("[TB] FAIL pause status: got busy=%b halted=%b pc=%h expected busy=%b halted=%b pc=%h",
                     busy_o, halted_o, rom_addr_o, kind == K_RUNNING, kind == K_HALTED, 8'(pc_mid));
        end
        enable_run(f2);
        h = f2 + 120;
        model_exec(pc_mid, f2, NEVER, h, pc_end, kind);
        wait_until(h);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL pause strobe count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL pause strobe[%0d]: got cyc=%0d a=%h d=%h expected cyc=%0d a=%h d=%h",
                         i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
            end
        end
        checks++;
        if (halted_o !== (kind == K_HALTED)) begin
            errors++;
            $display("[TB] FAIL pause halted: got %b expected %b", halted_o, kind == K_HALTED);
        end
    endtask

    task automatic test_restart();
        int f, r, h, pc_end, kind;
        rom_clear();
        rom[0] = cmd_write(4'h7, 8'h3C);
        rom[1] = cmd_wait(3);
        rom[2] = cmd_write(4'h8, 8'hC3);
        restart_to_idle();
        enable_run(f);
        r = f + 15 + $urandom_range(0, 11);
        model_exec(0, f, NEVER, r, pc_end, kind);
        wait_until(r);
        restart_i = 1'b1;
        @(negedge clk);
        restart_i = 1'b0;
        checks++;
        if ({busy_o, halted_o, strobe_o, rom_addr_o, data_o, addr_o} !== {3'b000, 8'h00, exp_q[$].data, exp_q[$].addr}) begin
            errors++;
            $display("[TB] FAIL restart in wait: got busy=%b halted=%b strobe=%b pc=%h data=%h addr=%h expected 0 0 0 00 %h %h",
                     busy_o, halted_o, strobe_o, rom_addr_o, data_o, addr_o, exp_q[$].data, exp_q[$].addr);
        end
        h = r + 2 + 60;
        model_exec(0, r + 2, NEVER, h, pc_end, kind);
        wait_until(h);
        checks++;
        if (halted_o !== (kind == K_HALTED)) begin
            errors++;
            $display("[TB] FAIL restart replay halted: got %b expected %b", halted_o, kind == K_HALTED);
        end
        r = cyc;
        restart_i = 1'b1;
        @(negedge clk);
        restart_i = 1'b0;
        checks++;
        if ({busy_o, halted_o, rom_addr_o} !== {2'b00, 8'h00}) begin
            errors++;
            $display("[TB] FAIL restart in halt: got busy=%b halted=%b pc=%h expected 0 0 00", busy_o, halted_o, rom_addr_o);
        end
        h = r + 2 + 60;
        model_exec(0, r + 2, NEVER, h, pc_end, kind);
        wait_until(h);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL restart strobe count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL restart strobe[%0d]: got cyc=%0d a=%h d=%h expected cyc=%0d a=%h d=%h",
                         i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_random();
        int f, h, len, pc_end, kind, pick;
        for (int p = 0; p < 4; p++) begin
            rom_clear();
            len = $urandom_range(3, 8);
            for (int i = 0; i < len; i++) begin
                pick = $urandom_range(0, 3);
                if (pick < 2) rom[i] = cmd_write(4'($urandom), 8'($urandom)) | {2'b00, 2'($urandom), 12'h000};
                else if (pick == 2) rom[i] = cmd_wait($urandom_range(0, 3));
                else rom[i] = cmd_jump(i + 1) | {2'b00, 6'($urandom), 8'h00};
            end
            rom[len] = 16'hC000 | 16'($urandom_range(0, 16'h3FFF));
            restart_to_idle();
            enable_run(f);
            h = f + 140;
            model_exec(0, f, NEVER, h, pc_end, kind);
            wait_until(h);
            checks++;
            if (obs_q.size() !== exp_q.size()) begin
                errors++;
                $display("[TB] FAIL random%0d strobe count: got %0d expected %0d", p, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("[TB] FAIL random%0d strobe[%0d]: got cyc=%0d a=%h d=%h expected cyc=%0d a=%h d=%h",
                             p, i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
                end
            end
            checks++;
            if ({halted_o, busy_o, rom_addr_o} !== {kind == K_HALTED, kind == K_RUNNING, 8'(pc_end)}) begin
                errors++;
                $display("[TB] FAIL random%0d final: got halted=%b busy=%b pc=%h expected halted=%b busy=%b pc=%h",
                         p, halted_o, busy_o, rom_addr_o, kind == K_HALTED, kind == K_RUNNING, 8'(pc_end));
            end
        end
    endtask

    task automatic test_async_reset();
        int f;
        rom_clear();
        rom[0] = cmd_write(4'h9, 8'hE7);
        rom[1] = cmd_jump(0);
        restart_to_idle();
        enable_run(f);
        wait_until(f + 30);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({data_o, addr_o, strobe_o, busy_o, halted_o, rom_addr_o} !== '0) begin
            errors++;
            $display("[TB] FAIL async reset: got data=%h addr=%h strobe=%b busy=%b halted=%b pc=%h expected all 0",
                     data_o, addr_o, strobe_o, busy_o, halted_o, rom_addr_o);
        end
        enable_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rom_clear();
        test_reset();
        test_basic_writes();
        test_wait();
        test_jump_loop();
        test_wrap();
        test_pause();
        test_restart();
        test_random();
        test_async_reset();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
